// File: rtl/pixel_write_fifo.sv
// ============================================================================
// Module   : pixel_write_fifo
// Brief    : First-word fall-through queue of (hpos, vpos, RGB) write requests
//            from the brush to the framebuffer, with occupancy level,
//            almost-full flag and a saturating drop counter.
//            Optional macro PIXEL_WRITE_FIFO_COALESCE_EN lets a push that
//            repeats the newest queued address overwrite its colour in place.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module pixel_write_fifo #(
    parameter int HPOS_WIDTH  = 10,
    parameter int VPOS_WIDTH  = 10,
    parameter int RGB_WIDTH   = 3,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 14,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [HPOS_WIDTH-1:0]      hpos_write,
    input  logic [VPOS_WIDTH-1:0]      vpos_write,
    input  logic [RGB_WIDTH-1:0]       RGB_write,
    input  logic                       pop,
    output logic [HPOS_WIDTH-1:0]      hpos_read,
    output logic [VPOS_WIDTH-1:0]      vpos_read,
    output logic [RGB_WIDTH-1:0]       RGB_read,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_WIDTH-1:0]      drop_count
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_lvl_w  = c_ptr_w + 1;
    localparam int c_data_w = HPOS_WIDTH + VPOS_WIDTH + RGB_WIDTH;

    localparam logic [c_ptr_w-1:0]    c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0]    c_lvl_one  = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0]    c_lvl_full = c_lvl_w'(DEPTH);
    localparam logic [DROP_WIDTH-1:0] c_drop_one = DROP_WIDTH'(1);

    logic [c_data_w-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_lvl_w-1:0]    r_level;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_full;
    logic [DROP_WIDTH-1:0] r_drop_count;

    logic                  w_do_pop;
    logic                  w_hit;
    logic                  w_append;
    logic                  w_drop;
    logic [c_ptr_w-1:0]    w_wr_addr;
    logic [c_lvl_w-1:0]    w_level_nxt;
    logic [c_data_w-1:0]   w_head;

    // A pop on an empty queue is ignored, which also makes push+pop on empty a plain push.
    assign w_do_pop = pop & ~r_empty & ~clear;

`ifdef PIXEL_WRITE_FIFO_COALESCE_EN
    logic                  r_tail_valid;
    logic [HPOS_WIDTH-1:0] r_tail_hpos;
    logic [VPOS_WIDTH-1:0] r_tail_vpos;
    logic                  w_tail_live;

    // The newest entry stops being a merge target once it is popped as the sole entry.
    assign w_tail_live = r_tail_valid & ~((r_level == c_lvl_one) & pop);
    assign w_hit       = push & ~clear & w_tail_live &
                         (hpos_write == r_tail_hpos) & (vpos_write == r_tail_vpos);
    assign w_wr_addr   = w_hit ? (r_wr_ptr - c_ptr_one) : r_wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tail_valid <= 1'b0;
            r_tail_hpos  <= '0;
            r_tail_vpos  <= '0;
        end else if (clear) begin
            r_tail_valid <= 1'b0;
        end else if (w_append) begin
            r_tail_valid <= 1'b1;
            r_tail_hpos  <= hpos_write;
            r_tail_vpos  <= vpos_write;
        end else if (w_do_pop && (r_level == c_lvl_one)) begin
            r_tail_valid <= 1'b0;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_wr_addr = r_wr_ptr;
`endif

    assign w_append = push & ~clear & ~w_hit & (~r_full | pop);
    assign w_drop   = push & ~clear & ~w_hit & r_full & ~pop;

    always_comb begin
        w_level_nxt = r_level;
        if (clear) begin
            w_level_nxt = '0;
        end else begin
            case ({w_append, w_do_pop})
                2'b10:   w_level_nxt = r_level + c_lvl_one;
                2'b01:   w_level_nxt = r_level - c_lvl_one;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_append) r_wr_ptr <= r_wr_ptr + c_ptr_one;
                if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_level       <= w_level_nxt;
            r_empty       <= (w_level_nxt == '0);
            r_full        <= (w_level_nxt == c_lvl_full);
            r_almost_full <= (int'(w_level_nxt) >= AFULL_LEVEL);
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + c_drop_one;
            end
        end
    end

    // Storage carries no reset; the empty flag masks any stale contents.
    always_ff @(posedge clk) begin
        if (w_append || w_hit) begin
            r_mem[w_wr_addr] <= {hpos_write, vpos_write, RGB_write};
        end
    end

    assign w_head = r_empty ? '0 : r_mem[r_rd_ptr];

    assign hpos_read   = w_head[c_data_w-1 -: HPOS_WIDTH];
    assign vpos_read   = w_head[RGB_WIDTH +: VPOS_WIDTH];
    assign RGB_read    = w_head[RGB_WIDTH-1:0];
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign level       = r_level;
    assign drop_count  = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_fifo.sv
// ============================================================================
// Module   : tb_pixel_write_fifo
// Brief    : Self-checking bench for pixel_write_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_write_fifo;

    localparam int HW    = 10;
    localparam int VW    = 10;
    localparam int RW    = 3;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;
    localparam int DRW   = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int SW    = LW + 3 + DRW + HW + VW + RW;
    localparam int DMAX  = (1 << DRW) - 1;
`ifdef PIXEL_WRITE_FIFO_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct packed {
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic [RW-1:0] c;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          push;
    logic [HW-1:0] hpos_write;
    logic [VW-1:0] vpos_write;
    logic [RW-1:0] RGB_write;
    logic          pop;
    logic [HW-1:0] hpos_read;
    logic [VW-1:0] vpos_read;
    logic [RW-1:0] RGB_read;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [LW-1:0] level;
    logic [DRW-1:0] drop_count;

    ent_t q[$];
    int   m_drops;
    int   n_tests;
    int   n_fail;

    pixel_write_fifo #(
        .HPOS_WIDTH (HW),
        .VPOS_WIDTH (VW),
        .RGB_WIDTH  (RW),
        .DEPTH      (DEPTH),
        .AFULL_LEVEL(AFULL),
        .DROP_WIDTH (DRW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .push       (push),
        .hpos_write (hpos_write),
        .vpos_write (vpos_write),
        .RGB_write  (RGB_write),
        .pop        (pop),
        .hpos_read  (hpos_read),
        .vpos_read  (vpos_read),
        .RGB_read   (RGB_read),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .level      (level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    wire [SW-1:0] dut_status = {level, empty, full, almost_full, drop_count,
                                hpos_read, vpos_read, RGB_read};

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            assert (level <= LW'(DEPTH))
            else begin
                $display("FAIL level_bound: level %0d exceeds %0d", level, DEPTH);
                n_fail++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [SW-1:0] exp_status();
        ent_t hd;
        hd = (q.size() > 0) ? q[0] : '0;
        return {LW'(q.size()), (q.size() == 0), (q.size() == DEPTH),
                (q.size() >= AFULL), DRW'(m_drops), hd};
    endfunction

    function automatic ent_t mk(input int h, input int v, input int c);
        ent_t e;
        e.h = HW'(h);
        e.v = VW'(v);
        e.c = RW'(c);
        return e;
    endfunction

    // Drive one cycle and advance the queue model by the rules for that cycle.
    task automatic step(input bit p, input ent_t e, input bit pp, input bit clr);
        int   n;
        bit   hit;
        ent_t t;
        push = p; hpos_write = e.h; vpos_write = e.v; RGB_write = e.c;
        pop = pp; clear = clr;
        n = q.size();
        hit = 1'b0;
        if (clr) begin
            q.delete();
        end else begin
            if (COAL && p && n > 0 && !(n == 1 && pp) && q[n-1].h == e.h && q[n-1].v == e.v)
                hit = 1'b1;
            if (hit) begin
                t = q[n-1];
                t.c = e.c;
                q[n-1] = t;
            end else if (p && n == DEPTH && !pp && m_drops < DMAX) begin
                m_drops++;
            end
            if (pp && n > 0) void'(q.pop_front());
            if (p && !hit && (n < DEPTH || pp)) q.push_back(e);
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        m_drops = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [SW-1:0] exp0;
        exp0 = '0;
        exp0[SW-LW-1] = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dut_status !== exp0) begin
            n_fail++; $display("FAIL reset_held: got %h expected %h", dut_status, exp0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (dut_status !== exp0) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", dut_status, exp0);
        end
    endtask

    task automatic test_basic();
        step(1, mk(5, 7, 1), 0, 0);
        step(1, mk(6, 7, 2), 0, 0);
        step(1, mk(7, 7, 4), 0, 0);
        n_tests++;
        if (level !== LW'(3) || empty !== 1'b0 || {hpos_read, vpos_read, RGB_read} !== mk(5, 7, 1)) begin
            n_fail++;
            $display("FAIL basic_fill: level %0d empty %b head %h, expected 3 0 %h",
                     level, empty, {hpos_read, vpos_read, RGB_read}, mk(5, 7, 1));
        end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 0);
            n_tests++;
            if (dut_status !== exp_status()) begin
                n_fail++; $display("FAIL basic_pop%0d: got %h expected %h", i, dut_status, exp_status());
            end
        end
        n_tests++;
        if (empty !== 1'b1 || {hpos_read, vpos_read, RGB_read} !== '0) begin
            n_fail++; $display("FAIL basic_drained: empty %b head %h, expected 1 0", empty,
                               {hpos_read, vpos_read, RGB_read});
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, mk(100 + i, i, i), 0, 0);
            n_tests++;
            if (dut_status !== exp_status()) begin
                n_fail++; $display("FAIL fill%0d: got %h expected %h", i, dut_status, exp_status());
            end
        end
        step(1, mk(400, 1, 5), 0, 0);
        n_tests++;
        if (drop_count !== DRW'(1) || level !== LW'(DEPTH) || full !== 1'b1) begin
            n_fail++; $display("FAIL full_drop: drop %0d level %0d full %b, expected 1 %0d 1",
                               drop_count, level, full, DEPTH);
        end
        step(1, mk(500, 9, 6), 1, 0);
        n_tests++;
        if (dut_status !== exp_status()) begin
            n_fail++; $display("FAIL full_pushpop: got %h expected %h", dut_status, exp_status());
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, '0, 1, 0);
            n_tests++;
            if (dut_status !== exp_status()) begin
                n_fail++; $display("FAIL drain%0d: got %h expected %h", i, dut_status, exp_status());
            end
        end
    endtask

    task automatic test_push_pop_empty();
        step(1, mk(1, 1, 7), 1, 0);
        n_tests++;
        if (level !== LW'(1) || {hpos_read, vpos_read, RGB_read} !== mk(1, 1, 7)) begin
            n_fail++; $display("FAIL pushpop_empty: level %0d head %h, expected 1 %h",
                               level, {hpos_read, vpos_read, RGB_read}, mk(1, 1, 7));
        end
        step(0, '0, 1, 0);
    endtask

    task automatic test_clear_reset();
        int saved_drops;
        for (int i = 0; i < 10; i++) step(1, mk(200 + i, 3, i), 0, 0);
        saved_drops = m_drops;
        step(1, mk(300, 3, 3), 0, 1);
        n_tests++;
        if (dut_status !== exp_status() || drop_count !== DRW'(saved_drops)) begin
            n_fail++; $display("FAIL clear: got %h expected %h", dut_status, exp_status());
        end
        for (int i = 0; i < 5; i++) step(1, mk(50 + i, 2, i), 0, 0);
        reset_n = 1'b0;
        q.delete();
        m_drops = 0;
        #1;
        n_tests++;
        if (dut_status !== exp_status()) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", dut_status, exp_status());
        end
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (dut_status !== exp_status()) begin
            n_fail++; $display("FAIL after_reset: got %h expected %h", dut_status, exp_status());
        end
    endtask

`ifdef PIXEL_WRITE_FIFO_COALESCE_EN
    task automatic test_coalesce();
        int d;
        step(1, mk(20, 30, 1), 0, 0);
        step(1, mk(20, 30, 6), 0, 0);
        n_tests++;
        if (level !== LW'(1) || RGB_read !== RW'(6)) begin
            n_fail++; $display("FAIL coalesce_merge: level %0d rgb %0d, expected 1 6", level, RGB_read);
        end
        step(0, '0, 1, 0);
        step(1, mk(20, 30, 1), 0, 0);
        step(1, mk(20, 30, 3), 1, 0);
        n_tests++;
        if (level !== LW'(1) || RGB_read !== RW'(3)) begin
            n_fail++; $display("FAIL coalesce_popped: level %0d rgb %0d, expected 1 3", level, RGB_read);
        end
        for (int i = 1; i < DEPTH; i++) step(1, mk(600 + i, 4, i), 0, 0);
        d = m_drops;
        step(1, mk(600 + DEPTH - 1, 4, 2), 0, 0);
        n_tests++;
        if (drop_count !== DRW'(d) || level !== LW'(DEPTH) || dut_status !== exp_status()) begin
            n_fail++; $display("FAIL coalesce_full: got %h expected %h", dut_status, exp_status());
        end
        while (q.size() > 0) step(0, '0, 1, 0);
    endtask
`else
    task automatic test_no_coalesce();
        step(1, mk(20, 30, 1), 0, 0);
        step(1, mk(20, 30, 1), 0, 0);
        n_tests++;
        if (level !== LW'(2)) begin
            n_fail++; $display("FAIL nocoal_level: level %0d, expected 2", level);
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({hpos_read, vpos_read, RGB_read} !== mk(20, 30, 1) || empty !== 1'b0) begin
                n_fail++; $display("FAIL nocoal_read%0d: head %h, expected %h", i,
                                   {hpos_read, vpos_read, RGB_read}, mk(20, 30, 1));
            end
            step(0, '0, 1, 0);
        end
    endtask
`endif

    task automatic test_random();
        bit p, pp, clr;
        int push_pct, pop_pct;
        for (int i = 0; i < 600; i++) begin
            push_pct = ((i / 60) % 2 == 0) ? 80 : 30;
            pop_pct  = ((i / 60) % 2 == 0) ? 25 : 70;
            p   = ($urandom_range(0, 99) < push_pct);
            pp  = ($urandom_range(0, 99) < pop_pct);
            clr = ($urandom_range(0, 99) < 2);
            step(p, mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7)), pp, clr);
            n_tests++;
            if (dut_status !== exp_status()) begin
                n_fail++; $display("FAIL random%0d: got %h expected %h", i, dut_status, exp_status());
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, mk(100 + i, i, i), 0, 0);
        for (int i = 0; i < DMAX + 5; i++) begin
            step(1, mk(900, 900, i), 0, 0);
            n_tests++;
            if (dut_status !== exp_status()) begin
                n_fail++; $display("FAIL sat%0d: got %h expected %h", i, dut_status, exp_status());
            end
        end
        n_tests++;
        if (drop_count !== {DRW{1'b1}}) begin
            n_fail++; $display("FAIL sat_final: drop %0d, expected %0d", drop_count, DMAX);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; m_drops = 0;
        reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
        hpos_write = '0; vpos_write = '0; RGB_write = '0;
        test_reset();
        test_basic();
        test_full();
        test_push_pop_empty();
        test_clear_reset();
`ifdef PIXEL_WRITE_FIFO_COALESCE_EN
        test_coalesce();
`else
        test_no_coalesce();
`endif
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
